// File: rtl/wb_pkg.sv
// Shared types and constants for the fake Wishbone write controller.
package wb_pkg;

  localparam int WB_DATA_WIDTH      = 8;
  localparam int WB_TXN_COUNT_WIDTH = 32;

  typedef enum logic [1:0] {
    GAP  = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } wb_fake_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [WB_TXN_COUNT_WIDTH-1:0] sat_inc(
    input logic [WB_TXN_COUNT_WIDTH-1:0] v
  );
    return (v == '1) ? v : v + WB_TXN_COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/fifo_addr_gen.sv
// Wrap-around counter: resets to 0, steps by one on inc, wraps modulo 2^ADDR_WIDTH.
module fifo_addr_gen #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [ADDR_WIDTH-1:0] addr_reg;

  // Counter register; natural overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
    end else if (inc) begin
      addr_reg <= addr_reg + ADDR_WIDTH'(1);
    end
  end

  assign addr = addr_reg;

endmodule

// File: rtl/wb_fake_ctrl.sv
// Wishbone classic write-stream source: single-beat writes of an incrementing
// data word, separated by IDLE_CYCLES idle cycles, optionally stopping after
// MAX_TXNS completions. Define WB_FAKE_CTRL_ASSERT_EN to build in protocol
// assertions and a data-wrap cover point.
module wb_fake_ctrl
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH  = WB_DATA_WIDTH,
  parameter int IDLE_CYCLES = 2,
  parameter int MAX_TXNS    = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  output logic                          cyc_o,
  output logic                          stb_o,
  output logic                          we_o,
  output logic [DATA_WIDTH-1:0]         dat_o,
  input  logic                          ack_i,
  output logic [WB_TXN_COUNT_WIDTH-1:0] txn_count,
  output logic                          done
);

  // Gap counter must hold the value IDLE_CYCLES itself.
  localparam int GAP_W = $clog2(IDLE_CYCLES + 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_CYCLES);
  localparam logic [WB_TXN_COUNT_WIDTH-1:0] MAX_CNT = WB_TXN_COUNT_WIDTH'(MAX_TXNS);

  wb_fake_state_t                  state_reg, state_next;
  logic [GAP_W-1:0]                gap_reg, gap_next;
  logic [WB_TXN_COUNT_WIDTH-1:0]   txn_reg, txn_next, txn_inc;
  logic [DATA_WIDTH-1:0]           data_cnt;
  logic                            req_active;

  assign req_active = (state_reg == REQ);

  // Data word source; advances only on an accepted strobe.
  fifo_addr_gen #(
    .ADDR_WIDTH(DATA_WIDTH)
  ) u_data_cnt (
    .clk  (clk_i),
    .rst  (rst_i),
    .inc  (ack_i && stb_o),
    .addr (data_cnt)
  );

  // State, gap counter and completion counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= GAP;
      gap_reg   <= '0;
      txn_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gap_reg   <= gap_next;
      txn_reg   <= txn_next;
    end
  end

  // Next-state logic. Leaving REQ into GAP preloads the gap counter with 1 so
  // the post-ack idle window is IDLE_CYCLES long, while the post-reset window
  // (counter starting at 0) is one cycle longer.
  always_comb begin
    state_next = state_reg;
    gap_next   = gap_reg;
    txn_next   = txn_reg;
    txn_inc    = sat_inc(txn_reg);
    unique case (state_reg)
      GAP: begin
        if (gap_reg >= GAP_LAST) begin
          state_next = REQ;
          gap_next   = '0;
        end else begin
          gap_next = gap_reg + GAP_W'(1);
        end
      end
      REQ: begin
        if (ack_i) begin
          txn_next = txn_inc;
          if ((MAX_TXNS != 0) && (txn_inc == MAX_CNT)) begin
            state_next = DONE;
          end else if (IDLE_CYCLES == 0) begin
            state_next = REQ;
          end else begin
            state_next = GAP;
            gap_next   = GAP_W'(1);
          end
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = GAP;
        gap_next   = '0;
      end
    endcase
  end

  // Bus outputs are decoded from registered state only; ack_i never reaches them.
  assign cyc_o     = req_active;
  assign stb_o     = req_active;
  assign we_o      = req_active;
  assign dat_o     = data_cnt;
  assign txn_count = txn_reg;
  assign done      = (state_reg == DONE);

`ifdef WB_FAKE_CTRL_ASSERT_EN
  a_stb_cyc: assert property (@(posedge clk_i) disable iff (rst_i) stb_o |-> cyc_o);
  a_we_stb: assert property (@(posedge clk_i) disable iff (rst_i) we_o == stb_o);
  a_dat_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (stb_o && !ack_i) |=> $stable(dat_o));
  a_done_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_reg == DONE) |-> !cyc_o);
  c_dat_wrap: cover property (@(posedge clk_i) disable iff (rst_i)
    (stb_o && ack_i && (dat_o == '1)) ##1 (dat_o == '0));
`else
  // Protocol checks not built in this configuration.
`endif

endmodule

// File: tb/tb_wb_fake_ctrl.sv
// Scoreboard bench for wb_fake_ctrl (three parameterisations) and fifo_addr_gen.
module tb_wb_fake_ctrl;

  typedef struct {
    logic [7:0]  dat;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  // DUT A: defaults, ack either tied to stb or forced by the bench
  logic        rst_a = 1'b1, ack_tie_a = 1'b1, ack_force_a = 1'b0;
  logic        cyc_a, stb_a, we_a, ack_a, done_a;
  logic [7:0]  dat_a;
  logic [31:0] txn_a;
  assign ack_a = ack_tie_a ? stb_a : ack_force_a;

  wb_fake_ctrl dut_a (
    .clk_i(clk), .rst_i(rst_a), .cyc_o(cyc_a), .stb_o(stb_a), .we_o(we_a),
    .dat_o(dat_a), .ack_i(ack_a), .txn_count(txn_a), .done(done_a)
  );

  // DUT B: back-to-back, zero-wait device
  logic        rst_b = 1'b1;
  logic        cyc_b, stb_b, we_b, ack_b, done_b;
  logic [7:0]  dat_b;
  logic [31:0] txn_b;
  assign ack_b = stb_b;

  wb_fake_ctrl #(.IDLE_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .cyc_o(cyc_b), .stb_o(stb_b), .we_o(we_b),
    .dat_o(dat_b), .ack_i(ack_b), .txn_count(txn_b), .done(done_b)
  );

  // DUT C: stops after four transactions
  logic        rst_c = 1'b1;
  logic        cyc_c, stb_c, we_c, ack_c, done_c;
  logic [7:0]  dat_c;
  logic [31:0] txn_c;
  assign ack_c = stb_c;

  wb_fake_ctrl #(.MAX_TXNS(4)) dut_c (
    .clk_i(clk), .rst_i(rst_c), .cyc_o(cyc_c), .stb_o(stb_c), .we_o(we_c),
    .dat_o(dat_c), .ack_i(ack_c), .txn_count(txn_c), .done(done_c)
  );

  // Standalone counter
  logic       rst_g = 1'b1, inc_g = 1'b0;
  logic [3:0] addr_g;

  fifo_addr_gen #(.ADDR_WIDTH(4)) u_gen (
    .clk(clk), .rst(rst_g), .inc(inc_g), .addr(addr_g)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: pop the scoreboard on every accepted strobe
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst_a && stb_a && ack_a) begin
      check("a_txn_expected", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        $display("txn a: dat=%0d count=%0d", dat_a, txn_a);
        check("a_dat", dat_a, e.dat);
        check("a_count", txn_a, e.cnt);
        check("a_we", we_a, 1);
        check("a_cyc", cyc_a, 1);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst_b && stb_b && ack_b) begin
      check("b_txn_expected", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        $display("txn b: dat=%0d count=%0d", dat_b, txn_b);
        check("b_dat", dat_b, e.dat);
        check("b_count", txn_b, e.cnt);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (!rst_c && stb_c && ack_c) begin
      check("c_txn_expected", 32'(q_c.size() != 0), 1);
      if (q_c.size() != 0) begin
        e = q_c.pop_front();
        $display("txn c: dat=%0d count=%0d", dat_c, txn_c);
        check("c_dat", dat_c, e.dat);
        check("c_count", txn_c, e.cnt);
      end
    end
  end

  // Two reset edges for DUT A; returns just after the last one
  task automatic reset_a();
    @(posedge clk); #1 rst_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0;
  endtask

  initial begin : stim
    logic found;

    // ---- A: defaults, zero-wait device, 20 cycles ----
    for (int i = 0; i < 6; i++) q_a.push_back('{dat: 8'(i), cnt: 32'(i)});
    reset_a();
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("a_rst_cyc", cyc_a, 0);
        check("a_rst_dat", dat_a, 0);
        check("a_rst_txn", txn_a, 0);
        check("a_rst_done", done_a, 0);
      end
      check("a_stb_pattern", stb_a, 32'((k % 3 == 0) && (k != 0)));
    end
    check("a_txn_after_20", txn_a, 6);
    check("a_queue_drained", q_a.size(), 0);

    // ---- A: device stalls first REQ ----
    ack_tie_a   = 1'b0;
    ack_force_a = 1'b0;
    q_a.push_back('{dat: 8'd0, cnt: 32'd0});
    reset_a();
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      check("a_stall_stb", stb_a, 32'(((k >= 3) && (k <= 8)) || (k == 11)));
      if (k >= 3 && k <= 8) check("a_stall_dat", dat_a, 0);
      if (k == 11) begin
        check("a_next_dat", dat_a, 1);
        check("a_next_txn", txn_a, 1);
      end
      if (k == 7) begin @(posedge clk); #1 ack_force_a = 1'b1; end
      if (k == 8) begin @(posedge clk); #1 ack_force_a = 1'b0; end
    end
    check("a_stall_drained", q_a.size(), 0);

    // ---- A: reset while REQ shows dat 7 ----
    for (int i = 0; i < 8; i++) q_a.push_back('{dat: 8'(i), cnt: 32'(i)});
    reset_a();
    ack_tie_a = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (stb_a && dat_a == 8'd7) found = 1'b1;
    end
    check("a_reach_dat7", found, 1);
    #1 rst_a = 1'b1;
    @(negedge clk);
    check("a_midrst_cyc", cyc_a, 0);
    check("a_midrst_txn", txn_a, 0);
    check("a_midrst_dat", dat_a, 0);
    q_a.push_back('{dat: 8'd0, cnt: 32'd0});
    @(posedge clk); #1 rst_a = 1'b0;
    for (int k = 0; k < 10 && q_a.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    rst_a = 1'b1;
    check("a_first_after_rst", q_a.size(), 0);

    // ---- B: back-to-back, 300 transactions ----
    for (int i = 0; i < 300; i++) q_b.push_back('{dat: 8'(i), cnt: 32'(i)});
    @(posedge clk); #1 rst_b = 1'b0;
    @(negedge clk);
    check("b_rst_stb", stb_b, 0);
    check("b_rst_txn", txn_b, 0);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      check("b_stb_cont", stb_b, 1);
      if (k == 256) check("b_dat_max", dat_b, 255);
      if (k == 257) check("b_dat_wrap", dat_b, 0);
    end
    check("b_txn_end", txn_b, 299);
    check("b_dat_end", dat_b, 43);
    #1 rst_b = 1'b1;
    check("b_queue_drained", q_b.size(), 0);

    // ---- C: MAX_TXNS = 4 ----
    for (int i = 0; i < 4; i++) q_c.push_back('{dat: 8'(i), cnt: 32'(i)});
    @(posedge clk); #1 rst_c = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      check("c_done", done_c, 32'(k >= 13));
      if (k >= 13) check("c_cyc_low", cyc_c, 0);
    end
    check("c_txn_final", txn_c, 4);
    check("c_dat_final", dat_c, 4);
    check("c_queue_drained", q_c.size(), 0);

    // ---- fifo_addr_gen standalone ----
    @(posedge clk); #1 rst_g = 1'b0;
    @(negedge clk);
    check("g_rst", addr_g, 0);
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1 inc_g = 1'b1;
      @(posedge clk); #1 inc_g = 1'b0;
      @(negedge clk);
      check("g_addr", addr_g, 32'((i + 1) % 16));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("g_hold", addr_g, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_fake_ctrl.md
# wb_fake_ctrl

Wishbone classic controller that generates a continuous stream of single-byte write transactions with incrementing data. It is the upstream stimulus source for FIFO benches and formal harnesses, and drives the write-side device port of the block under test. Data sequencing uses the `fifo_addr_gen` wrap-around counter.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of `dat_o` and of the data counter.
- `IDLE_CYCLES`, 2: number of cycles with `cyc_o`/`stb_o` low between transactions, and after reset release. 0 means back-to-back transactions.
- `MAX_TXNS`, 0: number of transactions to issue before stopping. 0 means unlimited.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`, input, 1: clock; all logic is on the rising edge.
- `rst_i`, input, 1: synchronous active-high reset.
- `cyc_o`, output, 1: bus cycle active.
- `stb_o`, output, 1: strobe; always equal to `cyc_o`.
- `we_o`, output, 1: write enable; always equal to `stb_o`.
- `dat_o`, output, DATA_WIDTH: write data.
- `ack_i`, input, 1: device acknowledge.
- `txn_count`, output, 32: number of completed transactions.
- `done`, output, 1: high once `MAX_TXNS` transactions have completed.

## Operation
- State machine with three states: GAP, REQ, DONE.
- **GAP**
  - Gap counter increments each cycle.
  - When the count reaches `IDLE_CYCLES`, the state becomes REQ and the gap counter clears.
  - If `IDLE_CYCLES` is 0, GAP lasts exactly one cycle, and only after reset.
- **REQ**
  - `cyc_o`, `stb_o` and `we_o` are high, and `dat_o` equals the data counter.
  - All outputs hold while `ack_i` is low. There is no timeout.
  - On a clock edge with `ack_i` high:
    - The data counter increments, wrapping from 2^DATA_WIDTH−1 to 0.
    - `txn_count` increments.
    - Next state is DONE if the new count equals `MAX_TXNS` (with `MAX_TXNS` nonzero).
    - Otherwise next state is GAP, or stays REQ when `IDLE_CYCLES` is 0.
- **DONE**: all bus outputs low and `done` high until reset.
- `ack_i` is ignored outside REQ.
- `txn_count` saturates at 2^32−1.
- Data counter: an instance of `fifo_addr_gen` with `ADDR_WIDTH = DATA_WIDTH`, `inc = ack_i && stb_o`.

## Timing
- Reset values (takes effect at the first rising edge with `rst_i` high):
  - `cyc_o`, `stb_o`, `we_o`, `done` = 0; `dat_o` = 0; `txn_count` = 0.
  - State = GAP, gap counter = 0.
- All outputs are registered or decoded from registered state. There is no combinational path from `ack_i` to any output.
- First `stb_o` rises `IDLE_CYCLES`+1 cycles after the last reset cycle (one cycle when `IDLE_CYCLES` is 0).
- A completing `ack_i` sampled at edge N:
  - Bus outputs are low from cycle N+1 for `IDLE_CYCLES` cycles.
  - With `IDLE_CYCLES` = 0, `stb_o` stays high and `dat_o` shows the incremented value at N+1.
- Zero-wait device (`ack_i` tied to `stb_o`): one transaction every `IDLE_CYCLES`+1 cycles.
- Reset asserted mid-REQ: bus outputs drop after that edge; the counter returns to 0. The aborted transaction is not counted.

## Configuration
- Macro `WB_FAKE_CTRL_ASSERT_EN`. When defined, the block includes concurrent assertions, clocked on `clk_i` and disabled during `rst_i`:
  - `stb_o` implies `cyc_o`.
  - `we_o` equals `stb_o`.
  - `dat_o` is stable while `stb_o` is high and `ack_i` is low.
  - `cyc_o` is low in DONE.
  - Cover property: a wrap of `dat_o` from all-ones to 0.
- When the macro is undefined, the assertions are absent. Functional behaviour is identical either way.

## Structure
- Package `wb_pkg` holds:
  - the state enum typedef `wb_fake_state_t` (GAP, REQ, DONE);
  - the default data width constant `WB_DATA_WIDTH = 8`;
  - the `txn_count` width constant `WB_TXN_COUNT_WIDTH = 32`.
- Sub-module `fifo_addr_gen`:
  - parameter `ADDR_WIDTH`;
  - ports `clk`, `rst`, `inc`, `addr[ADDR_WIDTH-1:0]`;
  - `addr` resets to 0, increments on `inc`, and wraps modulo 2^ADDR_WIDTH.
  - It is tested standalone as well.

## Test plan
- Defaults, `ack_i` tied to `stb_o`, 20 cycles after reset → `dat_o` values 0,1,2… on strobes every 3rd cycle; `txn_count` = 6.
- Device holds `ack_i` low for 5 cycles in the first REQ → `dat_o` stays 0 and `stb_o` stays high for 5 cycles; the single ack completes the transaction; the next `dat_o` is 1.
- `IDLE_CYCLES` = 0, zero-wait device, 300 transactions → `stb_o` continuously high; `dat_o` wraps 255→0 at transaction 256.
- `MAX_TXNS` = 4 → after the 4th ack `done` = 1, `cyc_o` = 0 permanently, and `txn_count` = 4.
- Reset asserted while REQ with `dat_o` = 7 → next cycle `cyc_o` = 0 and `txn_count` = 0; after release the first `dat_o` is 0.
- `fifo_addr_gen` with `ADDR_WIDTH` = 4, 17 pulses of `inc` → `addr` sequence 0…15, 0, 1; `addr` holds when `inc` = 0.
